// File: rtl/pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg -- elastic pipeline register
//
// DEPTH stages of WIDTH-bit storage between two valid/ready interfaces. Items
// move forward whenever the stage ahead is empty or is itself moving, so
// bubbles collapse and a full pipe with a ready consumer streams one item per
// cycle. A synchronous flush drops every held item, and an occupancy count is
// kept in a register alongside the valid bits.
//
// Handshake: a transfer happens on a rising clock edge when valid and ready
// are both high in the preceding cycle. A producer holds valid (and its data)
// until the transfer. The ready output is combinational through the stage
// chain, so it may depend on out_ready in the same cycle.
//
// Parameters
//   WIDTH      data bits per stage (>= 1)
//   DEPTH      number of register stages (>= 1)
//   RESET_VAL  value loaded into every stage data register on reset
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset (0 = reset)
//   flush      in   synchronous clear of all stage valid bits
//   in_valid   in   upstream item present on in_data
//   in_ready   out  pipe can accept this cycle
//   in_data    in   upstream data, WIDTH bits
//   out_valid  out  last stage holds an item
//   out_ready  in   downstream accepts this cycle
//   out_data   out  last stage data (registered), WIDTH bits
//   count      out  number of occupied stages, 0..DEPTH
// -----------------------------------------------------------------------------
module pipe_reg #(
   parameter int                 WIDTH     = 8,
   parameter int                 DEPTH     = 2,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);

   // Stage 0 is the input stage, stage DEPTH-1 drives the output.
   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   // free[k]: stage k can take a new item at the next edge.
   // move[k]: the item in stage k leaves it at the next edge.
   // load[k]: stage k captures a new item at the next edge.
   logic [DEPTH-1:0] free;
   logic [DEPTH-1:0] move;
   logic [DEPTH-1:0] load;
   logic             accept;

   // Ready chain, evaluated from the output stage back to the input stage so
   // that a draining consumer frees every stage of a full pipe in one cycle.
   always_comb begin : ready_chain
      free = '0;
      move = '0;
      move[DEPTH-1] = v_q[DEPTH-1] & out_ready;
      free[DEPTH-1] = ~v_q[DEPTH-1] | move[DEPTH-1];
      for (int k = DEPTH - 2; k >= 0; k--) begin
         move[k] = v_q[k] & free[k+1];
         free[k] = ~v_q[k] | move[k];
      end
   end

   // Held low during reset and during flush so nothing is captured then.
   assign in_ready = free[0] & ~flush & reset;
   assign accept   = in_valid & in_ready;

   // Stage k > 0 captures from stage k-1 exactly when stage k-1 moves. During
   // a flush the data registers keep their contents; only valid bits clear.
   always_comb begin : load_sel
      load    = '0;
      load[0] = accept;
      for (int k = 1; k < DEPTH; k++) begin
         load[k] = move[k-1] & ~flush;
      end
   end

   always_comb begin : next_state
      v_d     = '0;
      count_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         d_d[k] = d_q[k];
      end

      d_d[0] = load[0] ? in_data : d_q[0];
      for (int k = 1; k < DEPTH; k++) begin
         d_d[k] = load[k] ? d_q[k-1] : d_q[k];
      end

      // A stage stays valid unless its item leaves without a replacement.
      for (int k = 0; k < DEPTH; k++) begin
         v_d[k] = ~flush & (load[k] | (v_q[k] & ~move[k]));
      end

      for (int k = 0; k < DEPTH; k++) begin
         count_d = count_d + CW'(v_d[k]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin : regs
      if (!reset) begin
         v_q     <= '0;
         count_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= RESET_VAL;
         end
      end else begin
         v_q     <= v_d;
         count_q <= count_d;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= d_d[k];
         end
      end
   end

   assign out_valid = v_q[DEPTH-1];
   assign out_data  = d_q[DEPTH-1];
   assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg -- bench for pipe_reg
//
// Main instance: DEPTH=2, WIDTH=8, RESET_VAL=0, tracked by a queue model where
// each held item remembers how many edges it has spent in the pipe. A second
// instance with DEPTH=4 exercises bubble collapse.
// -----------------------------------------------------------------------------
module tb_pipe_reg;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 2;
   localparam int DEPTH4 = 4;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT (DEPTH=2) ----------------
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       count;

   pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   // ---------------- second DUT (DEPTH=4) ----------------
   logic             d4_flush;
   logic             d4_in_valid;
   logic             d4_in_ready;
   logic [WIDTH-1:0] d4_in_data;
   logic             d4_out_valid;
   logic             d4_out_ready;
   logic [WIDTH-1:0] d4_out_data;
   logic [2:0]       d4_count;

   pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH4), .RESET_VAL(8'h00)) dut4 (
      .clk       (clk),
      .reset     (reset),
      .flush     (d4_flush),
      .in_valid  (d4_in_valid),
      .in_ready  (d4_in_ready),
      .in_data   (d4_in_data),
      .out_valid (d4_out_valid),
      .out_ready (d4_out_ready),
      .out_data  (d4_out_data),
      .count     (d4_count)
   );

   // ---------------- scoreboard / reference model ----------------
   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] exp_q[$];   // items held in the pipe, oldest first
   int               age_q[$];   // edges each item has spent in the pipe
   logic [WIDTH-1:0] got_q[$];   // items observed leaving the DUT

   // The oldest item advances every edge (nothing ahead of it), so it sits at
   // the output once it has been in the pipe for DEPTH-1 edges.
   function automatic bit m_out_valid();
      return (exp_q.size() > 0) && (age_q[0] >= DEPTH - 1);
   endfunction

   // A free stage anywhere lets the input stage take an item; a full pipe
   // can only take one when the output is draining.
   function automatic bit m_in_ready();
      return reset && !flush && ((exp_q.size() < DEPTH) || out_ready);
   endfunction

   function automatic logic [1:0] m_count();
      return 2'(exp_q.size());
   endfunction

   // ---------------- driver: advance one edge and update the model ---------
   task automatic tick();
      bit dlv;
      bit acc;
      dlv = m_out_valid() && out_ready;
      acc = in_valid && m_in_ready();
      if (out_valid && out_ready) got_q.push_back(out_data);
      foreach (age_q[i]) age_q[i]++;
      if (dlv) begin
         void'(exp_q.pop_front());
         void'(age_q.pop_front());
      end
      if (flush) begin
         exp_q.delete();
         age_q.delete();
      end
      if (acc) begin
         exp_q.push_back(in_data);
         age_q.push_back(0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         errors++;
         $display("FAIL drain: out_valid=%0b count=%0d, required 0/0", out_valid, count);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      flush = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== 8'h00 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: ov=%0b cnt=%0d od=%h ir=%0b, required 0 0 00 0",
                  out_valid, count, out_data, in_ready);
      end
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_clocked: ov=%0b cnt=%0d od=%h, required 0 0 00", out_valid, count, out_data);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %0b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd1) begin
         errors++;
         $display("FAIL reset_first_edge: ov=%0b cnt=%0d, required 0 1", out_valid, count);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
         errors++;
         $display("FAIL reset_first_item: ov=%0b od=%h, required 1 a5", out_valid, out_data);
      end
      drain();
   endtask

   task automatic test_streaming();
      got_q.delete();
      out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready i=%0d: got %0b required 1", i, in_ready);
         end
         checks++;
         if (out_valid !== m_out_valid() || count !== m_count()) begin
            errors++;
            $display("FAIL stream_state i=%0d: ov=%0b cnt=%0d required %0b %0d",
                     i, out_valid, count, m_out_valid(), m_count());
         end
         if (i >= 3) begin
            checks++;
            if (count !== 2'd2) begin
               errors++;
               $display("FAIL stream_count i=%0d: got %0d required 2", i, count);
            end
         end
         if (m_out_valid()) begin
            checks++;
            if (out_data !== exp_q[0]) begin
               errors++;
               $display("FAIL stream_data i=%0d: got %h required %h", i, out_data, exp_q[0]);
            end
         end
         tick();
      end
      drain();
      checks++;
      if (got_q.size() != 16) begin
         errors++;
         $display("FAIL stream_len: got %0d items required 16", got_q.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_q[i] !== 8'(i + 1)) begin
               errors++;
               $display("FAIL stream_order idx=%0d: got %h required %h", i, got_q[i], 8'(i + 1));
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [WIDTH-1:0] want [3];
      want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
      got_q.delete();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      tick();
      in_data   = 8'h22;
      tick();
      in_data   = 8'h33;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || count !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL stall_hold c=%0d: ir=%0b cnt=%0d ov=%0b od=%h, required 0 2 1 11",
                     c, in_ready, count, out_valid, out_data);
         end
         tick();
      end
      out_ready = 1'b1;
      for (int c = 0; c < 10 && (in_valid || exp_q.size() > 0); c++) begin
         #1;
         checks++;
         if (out_valid !== m_out_valid() || count !== m_count() || in_ready !== m_in_ready()) begin
            errors++;
            $display("FAIL stall_release c=%0d: ov=%0b cnt=%0d ir=%0b required %0b %0d %0b",
                     c, out_valid, count, in_ready, m_out_valid(), m_count(), m_in_ready());
         end
         if (in_valid && m_in_ready()) begin
            tick();
            in_valid = 1'b0;
         end else begin
            tick();
         end
      end
      drain();
      checks++;
      if (got_q.size() != 3) begin
         errors++;
         $display("FAIL stall_len: got %0d items required 3", got_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q[i] !== want[i]) begin
               errors++;
               $display("FAIL stall_order idx=%0d: got %h required %h", i, got_q[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_flush();
      got_q.delete();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h41;
      tick();
      in_data   = 8'h42;
      tick();
      in_data   = 8'h43;
      flush     = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0 || count !== 2'd2) begin
         errors++;
         $display("FAIL flush_cycle: ir=%0b cnt=%0d, required 0 2", in_ready, count);
      end
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         errors++;
         $display("FAIL flush_after: ov=%0b cnt=%0d, required 0 0", out_valid, count);
      end
      checks++;
      if (out_data !== 8'h41) begin
         errors++;
         $display("FAIL flush_data_held: got %h required 41", out_data);
      end
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0 || got_q.size() != 0) begin
         errors++;
         $display("FAIL flush_no_capture: ov=%0b cnt=%0d delivered=%0d, required 0 0 0",
                  out_valid, count, got_q.size());
      end
   endtask

   task automatic test_bubble_collapse();
      d4_flush = 1'b0; d4_out_ready = 1'b0;
      d4_in_valid = 1'b1; d4_in_data = 8'hB1;
      #1;
      checks++;
      if (d4_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bubble_ready: got %0b required 1", d4_in_ready);
      end
      tick();
      d4_in_valid = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (d4_out_valid !== 1'b1 || d4_out_data !== 8'hB1 || d4_count !== 3'd1) begin
         errors++;
         $display("FAIL bubble_first: ov=%0b od=%h cnt=%0d, required 1 b1 1",
                  d4_out_valid, d4_out_data, d4_count);
      end
      d4_in_valid = 1'b1; d4_in_data = 8'hB2;
      tick();
      d4_in_valid = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (d4_count !== 3'd2 || d4_out_data !== 8'hB1 || d4_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bubble_stalled: cnt=%0d od=%h ir=%0b, required 2 b1 1",
                  d4_count, d4_out_data, d4_in_ready);
      end
      d4_out_ready = 1'b1;
      tick();
      checks++;
      if (d4_out_valid !== 1'b1 || d4_out_data !== 8'hB2 || d4_count !== 3'd1) begin
         errors++;
         $display("FAIL bubble_adjacent: ov=%0b od=%h cnt=%0d, required 1 b2 1",
                  d4_out_valid, d4_out_data, d4_count);
      end
      tick();
      checks++;
      if (d4_out_valid !== 1'b0 || d4_count !== 3'd0 || d4_out_data !== 8'hB2) begin
         errors++;
         $display("FAIL bubble_empty: ov=%0b cnt=%0d od=%h, required 0 0 b2",
                  d4_out_valid, d4_count, d4_out_data);
      end
      d4_out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [WIDTH-1:0] want [4];
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h51 + 8'(i);
         tick();
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: ov=%0b cnt=%0d ir=%0b, required 0 0 0", out_valid, count, in_ready);
      end
      exp_q.delete();
      age_q.delete();
      tick();
      reset = 1'b1;
      got_q.delete();
      for (int i = 0; i < 4; i++) begin
         want[i]  = 8'hC1 + 8'(i);
         in_valid = 1'b1;
         in_data  = want[i];
         tick();
      end
      drain();
      checks++;
      if (got_q.size() != 4) begin
         errors++;
         $display("FAIL async_resume_len: got %0d items required 4", got_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i] !== want[i]) begin
               errors++;
               $display("FAIL async_resume idx=%0d: got %h required %h", i, got_q[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         #1;
         checks++;
         if (in_ready !== m_in_ready() || out_valid !== m_out_valid() || count !== m_count()) begin
            errors++;
            $display("FAIL random c=%0d: ir=%0b ov=%0b cnt=%0d required %0b %0b %0d",
                     c, in_ready, out_valid, count, m_in_ready(), m_out_valid(), m_count());
         end
         if (m_out_valid()) begin
            checks++;
            if (out_data !== exp_q[0]) begin
               errors++;
               $display("FAIL random_data c=%0d: got %h required %h", c, out_data, exp_q[0]);
            end
         end
         tick();
      end
      drain();
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      d4_flush = 1'b0; d4_in_valid = 1'b0; d4_in_data = '0; d4_out_ready = 1'b0;
      flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      test_streaming();
      test_stall();
      test_flush();
      test_bubble_collapse();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
